aes_cipher_sched: RTL and testbench

Round-robin scheduler sharing one `aes_cipher_top` encryption core among NREQ requesters. It accepts {key, plaintext} jobs over per-requester valid/ready channels and serializes them onto the core's `ld`/`done` interface. It returns each ciphertext, tagged with the requester ID, on a single response channel, with a watchdog for a core that never signals `done`.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_rr_arb.sv | 28 ++
 rtl/aes_cipher_sched.sv | 139 +++++++++++++
 tb/tb_aes_cipher_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core scheduler.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } aes_sched_state_e;

  typedef struct packed {
    logic [AES_BLK_W-1:0] key;
    logic [AES_BLK_W-1:0] text;
  } aes_job_t;

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid requester above 'last'.
module aes_rr_arb #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic            grant_vld,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] idx;

  // Walk from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/aes_cipher_sched.sv
// Round-robin scheduler sharing one AES core among NREQ requesters, with a
// completion watchdog and an ID-tagged response channel.
module aes_cipher_sched
  import aes_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*AES_BLK_W-1:0] req_key,
  input  logic [NREQ*AES_BLK_W-1:0] req_text,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [AES_BLK_W-1:0]      rsp_data,
  output logic                      rsp_err,
  output logic                      core_ld,
  output logic [AES_BLK_W-1:0]      core_key,
  output logic [AES_BLK_W-1:0]      core_text,
  input  logic                      core_done,
  input  logic [AES_BLK_W-1:0]      core_text_out,
  output logic                      busy,
  output logic [15:0]               done_cnt
);

  localparam int WDW = $clog2(TIMEOUT);

  aes_sched_state_e     state_q, state_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  aes_job_t             job_q, job_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [15:0]          done_cnt_q, done_cnt_d;
  logic                 grant_vld;
  logic [IDW-1:0]       grant_idx;

  aes_rr_arb #(.NREQ(NREQ)) u_arb (
    .valid     (req_valid),
    .last      (last_q),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Outputs decoded from state are gated by reset so they read zero while rst is low.
  always_comb begin
    req_ready = '0;
    if (rst && state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign core_ld   = rst && (state_q == LOAD);
  assign busy      = rst && (state_q != IDLE);
  assign rsp_valid = rst && (state_q == RESP);
  assign rsp_id    = cur_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign core_key  = job_q.key;
  assign core_text = job_q.text;
  assign done_cnt  = done_cnt_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_id_d   = cur_id_q;
    job_d      = job_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
              job_d.key  = req_key[i*AES_BLK_W +: AES_BLK_W];
              job_d.text = req_text[i*AES_BLK_W +: AES_BLK_W];
            end
          end
          cur_id_d = grant_idx;
          last_d   = grant_idx;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      // A done pulse in the final watchdog cycle still counts as success.
      BUSY: begin
        if (core_done) begin
          rsp_data_d = core_text_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (done_cnt_q != 16'hFFFF) done_cnt_d = done_cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= IDW'(NREQ - 1);
      cur_id_q   <= '0;
      job_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_q       <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cur_id_q   <= cur_id_d;
      job_q      <= job_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_cipher_sched.sv
// Self-checking bench for aes_cipher_sched with a 12-cycle behavioural AES core.
module tb_aes_cipher_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;
  localparam int IDW     = 2;
  localparam int LAT     = 12;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*128-1:0] req_key = '0;
  logic [NREQ*128-1:0] req_text = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [127:0]      rsp_data;
  logic              rsp_err;
  logic              core_ld;
  logic [127:0]      core_key, core_text;
  logic              core_done = 1'b0;
  logic [127:0]      core_text_out = '0;
  logic              busy;
  logic [15:0]       done_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_last = NREQ - 1;
  int exp_cnt = 0;
  int rem = 0;
  bit never_done = 1'b0;
  int inject_at = -1;

  aes_cipher_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in AES: the FIPS-197 example vector, otherwise an arbitrary keyed mix.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && t == T0) return C0;
    return k ^ {t[63:0], t[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(exp_last + k) % NREQ]) return (exp_last + k) % NREQ;
    return -1;
  endfunction

  // Core model: done pulses LAT cycles after the ld cycle; a new ld restarts it.
  always @(negedge clk) begin
    core_done     <= 1'b0;
    core_text_out <= ~cipher(core_key, core_text);
    if (!rst) rem <= 0;
    else if (core_ld) rem <= LAT;
    else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1 && !never_done) begin
        core_done     <= 1'b1;
        core_text_out <= cipher(core_key, core_text);
      end
    end
    if (cyc == inject_at) begin
      core_done     <= 1'b1;
      core_text_out <= cipher(core_key, core_text);
    end
  end

  task automatic do_job(input int r, input logic [127:0] k, input logic [127:0] t,
                        output int t_acc, output int t_rsp, output int gid,
                        output logic [IDW-1:0] id, output logic [127:0] data,
                        output logic err, output bit ok);
    ok = 1'b1; t_acc = -1; t_rsp = -1; gid = -1; id = '0; data = '0; err = 1'b0;
    req_key[r*128 +: 128]  = k;
    req_text[r*128 +: 128] = t;
    req_valid[r] = 1'b1;
    rsp_ready    = 1'b1;
    for (int i = 0; i < 100 && t_acc < 0; i++) begin
      @(negedge clk); #1;
      if (req_ready != '0) begin
        t_acc = cyc;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) gid = j;
      end
    end
    if (t_acc < 0) begin
      req_valid[r] = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    exp_last = gid;
    for (int i = 0; i < 100 && t_rsp < 0; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        t_rsp = cyc; id = rsp_id; data = rsp_data; err = rsp_err;
      end
    end
    if (t_rsp < 0) begin
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '1; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_err, core_ld, busy} !== '0)
      $display("[TB] FAIL reset_ctrl got=%0h exp=0", {req_ready, rsp_valid, rsp_id, rsp_err, core_ld, busy});
    if ({req_ready, rsp_valid, rsp_id, rsp_err, core_ld, busy} !== '0) errors++;
    checks++;
    if ({core_key, core_text, rsp_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%0h exp=0", {core_key, core_text, rsp_data});
    end
    checks++;
    if (done_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt got=%0h exp=0", done_cnt);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_last = NREQ - 1;
    exp_cnt = 0;
  endtask

  task automatic test_fair();
    logic [127:0] k[NREQ];
    logic [127:0] t[NREQ];
    logic [NREQ-1:0] oh;
    int qid[$];
    logic [127:0] qd[$];
    int accepts = 0, resps = 0, g, acc_idx;
    for (int j = 0; j < NREQ; j++) begin
      k[j] = rnd128(); t[j] = rnd128();
      req_key[j*128 +: 128] = k[j]; req_text[j*128 +: 128] = t[j];
    end
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 400 && resps < 6; c++) begin
      @(negedge clk); #1;
      acc_idx = -1;
      if (req_ready != '0) begin
        g = exp_grant(req_valid);
        oh = '0; oh[g] = 1'b1;
        checks++;
        if (req_ready !== oh) begin
          errors++;
          $display("[TB] FAIL fair_grant got=%b exp=%b", req_ready, oh);
        end
        checks++;
        if (g != accepts % NREQ) begin
          errors++;
          $display("[TB] FAIL fair_order got=%0d exp=%0d", g, accepts % NREQ);
        end
        qid.push_back(g); qd.push_back(cipher(k[g], t[g]));
        exp_last = g; accepts++; acc_idx = g;
      end
      if (rsp_valid) begin
        checks++;
        if (qid.size() == 0) begin
          errors++;
          $display("[TB] FAIL fair_rsp got=unexpected exp=none");
        end else begin
          if (rsp_id !== IDW'(qid[0]) || rsp_data !== qd[0] || rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fair_rsp got=%0d/%h/%b exp=%0d/%h/0", rsp_id, rsp_data, rsp_err, qid[0], qd[0]);
          end
          void'(qid.pop_front()); void'(qd.pop_front());
        end
        resps++;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
      @(posedge clk); #1;
      if (acc_idx >= 0) begin
        if (accepts >= 6) req_valid = '0;
        else begin
          k[acc_idx] = rnd128(); t[acc_idx] = rnd128();
          req_key[acc_idx*128 +: 128] = k[acc_idx]; req_text[acc_idx*128 +: 128] = t[acc_idx];
        end
      end
    end
    req_valid = '0;
    checks++;
    if (resps != 6) begin
      errors++;
      $display("[TB] FAIL fair_count got=%0d exp=6", resps);
    end
    checks++;
    if (done_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL fair_cnt got=%0d exp=%0d", done_cnt, exp_cnt);
    end
  endtask

  task automatic test_single();
    int ta, tr, g; logic [IDW-1:0] id; logic [127:0] d; logic e; bit ok;
    do_job(0, K0, T0, ta, tr, g, id, d, e, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_handshake got=timeout exp=response");
    end
    checks++;
    if (tr - ta != LAT + 2 || g != 0) begin
      errors++;
      $display("[TB] FAIL single_latency got=%0d/g%0d exp=%0d/g0", tr - ta, g, LAT + 2);
    end
    checks++;
    if (id !== 2'd0 || d !== C0 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_rsp got=%0d/%h/%b exp=0/%h/0", id, d, e, C0);
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] k3, t3, snap_d; logic [IDW-1:0] snap_id; logic snap_e;
    int ta = -1, tr = -1;
    k3 = rnd128(); t3 = rnd128();
    req_key[3*128 +: 128] = k3; req_text[3*128 +: 128] = t3;
    req_valid = 4'b1000; rsp_ready = 1'b0;
    for (int i = 0; i < 100 && ta < 0; i++) begin
      @(negedge clk); #1;
      if (req_ready[3]) ta = cyc;
    end
    @(posedge clk); #1;
    req_valid = 4'b0110;
    for (int j = 1; j <= 2; j++) begin
      req_key[j*128 +: 128] = rnd128(); req_text[j*128 +: 128] = rnd128();
    end
    for (int i = 0; i < 100 && tr < 0; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) tr = cyc;
    end
    snap_d = rsp_data; snap_id = rsp_id; snap_e = rsp_err;
    checks++;
    if (ta < 0 || tr < 0 || snap_id !== 2'd3 || snap_d !== cipher(k3, t3) || snap_e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_rsp got=%0d/%h/%b exp=3/%h/0", snap_id, snap_d, snap_e, cipher(k3, t3));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== snap_d || rsp_id !== snap_id || rsp_err !== snap_e ||
          req_ready !== '0 || core_ld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold got=v%b r%b ld%b d%h exp=v1 r0 ld0 d%h",
                 rsp_valid, req_ready, core_ld, rsp_data, snap_d);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    exp_last = 3;
    if (exp_cnt != 16'hFFFF) exp_cnt++;
    checks++;
    if (done_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL bp_cnt got=%0d exp=%0d", done_cnt, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int ta, tr, g; logic [IDW-1:0] id; logic [127:0] d, k, t; logic e; bit ok, bad;
    never_done = 1'b1;
    do_job(1, rnd128(), rnd128(), ta, tr, g, id, d, e, ok);
    checks++;
    if (!ok || tr - ta != TIMEOUT + 2) begin
      errors++;
      $display("[TB] FAIL to_latency got=%0d ok%b exp=%0d", tr - ta, ok, TIMEOUT + 2);
    end
    checks++;
    if (id !== 2'd1 || d !== '0 || e !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_rsp got=%0d/%h/%b exp=1/0/1", id, d, e);
    end
    inject_at = ta + 40;
    bad = 1'b0;
    for (int i = 0; i < 20 && cyc < ta + 43; i++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL to_stale_done got=activity exp=idle");
    end
    never_done = 1'b0; inject_at = -1;
    k = rnd128(); t = rnd128();
    do_job(2, k, t, ta, tr, g, id, d, e, ok);
    checks++;
    if (!ok || tr - ta != LAT + 2 || id !== 2'd2 || d !== cipher(k, t) || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_recover got=%0d/%0d/%h/%b exp=%0d/2/%h/0", tr - ta, id, d, e, LAT + 2, cipher(k, t));
    end
  endtask

  task automatic test_reset_mid();
    int ta = -1, tr, g; logic [IDW-1:0] id; logic [127:0] d, k0, t0; logic e; bit ok;
    req_key[1*128 +: 128] = rnd128(); req_text[1*128 +: 128] = rnd128();
    req_valid = 4'b0010; rsp_ready = 1'b1;
    for (int i = 0; i < 100 && ta < 0; i++) begin
      @(negedge clk); #1;
      if (req_ready[1]) ta = cyc;
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_busy got=%b exp=1", busy);
    end
    k0 = rnd128(); t0 = rnd128();
    req_key[0 +: 128] = k0; req_text[0 +: 128] = t0;
    req_key[2*128 +: 128] = rnd128(); req_text[2*128 +: 128] = rnd128();
    rst = 1'b0; req_valid = 4'b0101;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_err, core_ld, busy, done_cnt} !== '0 ||
        {core_key, core_text, rsp_data} !== '0) begin
      errors++;
      $display("[TB] FAIL rm_outputs got=%0h exp=0", {req_ready, rsp_valid, rsp_id, rsp_err, core_ld, busy, done_cnt});
    end
    rst = 1'b1; exp_last = NREQ - 1; exp_cnt = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rm_priority got=%b exp=0001", req_ready);
    end
    req_valid[2] = 1'b0;
    do_job(0, k0, t0, ta, tr, g, id, d, e, ok);
    checks++;
    if (!ok || g != 0 || id !== 2'd0 || d !== cipher(k0, t0) || e !== 1'b0 || done_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL rm_job got=%0d/%h/%0d exp=0/%h/%0d", id, d, done_cnt, cipher(k0, t0), exp_cnt);
    end
  endtask

  task automatic test_saturation();
    int ta, tr, g; logic [IDW-1:0] id; logic [127:0] d; logic e; bit ok;
    @(negedge clk);
    force dut.done_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.done_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int j = 0; j < 3; j++) begin
      do_job(j, rnd128(), rnd128(), ta, tr, g, id, d, e, ok);
      checks++;
      if (!ok || done_cnt !== 16'(exp_cnt) || done_cnt !== 16'hFFFF) begin
        errors++;
        $display("[TB] FAIL sat_cnt job%0d got=%h exp=ffff", j, done_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fair();
    test_single();
    test_back_pressure();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
